// File: rtl/npcg_toggle_pm_arbiter_pkg.sv
// Shared NPCG definitions for the toggle primitive-module arbiter: FSM state
// encodings, PM bus field widths and the executor-count limit.
package npcg_toggle_pm_arbiter_pkg;

  localparam int PCMD_W        = 8;   // primitive command
  localparam int PCMD_OPT_W    = 3;   // command option
  localparam int NUM_DATA_W    = 16;  // data count
  localparam int CA_DATA_W     = 8;   // CA data
  localparam int PM_STATUS_W   = 8;   // PM ready / last-step status
  localparam int MAX_EXECUTORS = 8;
  localparam int EXEC_ID_W     = 3;   // enough to index MAX_EXECUTORS

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'b001,
    ARB_OWN     = 3'b010,
    ARB_RELEASE = 3'b100
  } arb_state_e;

  // Binary index of a one-hot vector; returns 0 for an all-zero vector.
  function automatic logic [EXEC_ID_W-1:0] onehot_to_bin(
    input logic [MAX_EXECUTORS-1:0] oh
  );
    logic [EXEC_ID_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < MAX_EXECUTORS; i++) begin
      if (oh[i]) bin = bin | EXEC_ID_W'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/npcg_toggle_pm_arbiter_if.sv
// Executor-side and PM-side bus bundle of the toggle PM arbiter. The master
// modport is the executors plus PM block; the slave modport is the arbiter.
interface npcg_toggle_pm_arbiter_if #(
  parameter int NumberOfWays      = 4,
  parameter int NumberOfExecutors = 4
);
  import npcg_toggle_pm_arbiter_pkg::*;

  logic [NumberOfExecutors-1:0]              iExecReq;
  logic [NumberOfExecutors-1:0]              iExecLastStep;
  logic [NumberOfExecutors-1:0]              oExecGrant;
  logic [PCMD_W*NumberOfExecutors-1:0]       iExecPCommand;
  logic [PCMD_OPT_W*NumberOfExecutors-1:0]   iExecPCommandOption;
  logic [NumberOfWays*NumberOfExecutors-1:0] iExecTargetWay;
  logic [NUM_DATA_W*NumberOfExecutors-1:0]   iExecNumOfData;
  logic [NumberOfExecutors-1:0]              iExecCASelect;
  logic [CA_DATA_W*NumberOfExecutors-1:0]    iExecCAData;
  logic [PM_STATUS_W*NumberOfExecutors-1:0]  oExecPM_Ready;
  logic [PM_STATUS_W*NumberOfExecutors-1:0]  oExecPM_LastStep;
  logic [PM_STATUS_W-1:0]                    iPM_Ready;
  logic [PM_STATUS_W-1:0]                    iPM_LastStep;
  logic [PCMD_W-1:0]                         oPM_PCommand;
  logic [PCMD_OPT_W-1:0]                     oPM_PCommandOption;
  logic [NumberOfWays-1:0]                   oPM_TargetWay;
  logic [NUM_DATA_W-1:0]                     oPM_NumOfData;
  logic                                      oPM_CASelect;
  logic [CA_DATA_W-1:0]                      oPM_CAData;
  logic                                      oBusy;
  logic [EXEC_ID_W-1:0]                      oOwnerID;

  modport master (
    output iExecReq, iExecLastStep, iExecPCommand, iExecPCommandOption,
           iExecTargetWay, iExecNumOfData, iExecCASelect, iExecCAData,
           iPM_Ready, iPM_LastStep,
    input  oExecGrant, oExecPM_Ready, oExecPM_LastStep, oPM_PCommand,
           oPM_PCommandOption, oPM_TargetWay, oPM_NumOfData, oPM_CASelect,
           oPM_CAData, oBusy, oOwnerID
  );

  modport slave (
    input  iExecReq, iExecLastStep, iExecPCommand, iExecPCommandOption,
           iExecTargetWay, iExecNumOfData, iExecCASelect, iExecCAData,
           iPM_Ready, iPM_LastStep,
    output oExecGrant, oExecPM_Ready, oExecPM_LastStep, oPM_PCommand,
           oPM_PCommandOption, oPM_TargetWay, oPM_NumOfData, oPM_CASelect,
           oPM_CAData, oBusy, oOwnerID
  );

endinterface

// File: rtl/npcg_rr_picker.sv
// Round-robin picker: one-hot winner among i_req, searching upward from i_ptr
// and wrapping to index 0. Purely combinational.
module npcg_rr_picker
  import npcg_toggle_pm_arbiter_pkg::*;
#(
  parameter int NumberOfExecutors = 4
) (
  input  logic [NumberOfExecutors-1:0] i_req,
  input  logic [EXEC_ID_W-1:0]         i_ptr,
  output logic [NumberOfExecutors-1:0] o_winner
);

  logic [NumberOfExecutors-1:0] w_mask;
  logic [NumberOfExecutors-1:0] w_masked;
  logic [NumberOfExecutors-1:0] w_pool;

  // Requests at or above the pointer take precedence; if there are none the
  // search wraps and the lowest-index request overall wins.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_mask = '0;
    for (int j = 0; j < NumberOfExecutors; j++) begin
      w_mask[j] = (j >= int'(i_ptr));
    end
    w_masked = i_req & w_mask;
    w_pool   = (|w_masked) ? w_masked : i_req;
    o_winner = '0;
    for (int j = NumberOfExecutors - 1; j >= 0; j--) begin
      if (w_pool[j]) begin
        o_winner    = '0;
        o_winner[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/npcg_toggle_pm_arbiter.sv
// Toggle PM arbiter: grants PM-bus ownership to one executor at a time by
// round robin and muxes the owner's command fields onto the PM bus.
module npcg_toggle_pm_arbiter
  import npcg_toggle_pm_arbiter_pkg::*;
#(
  parameter int NumberOfWays      = 4,
  parameter int NumberOfExecutors = 4
) (
  input  logic                           iSystemClock,
  input  logic                           iReset,
  npcg_toggle_pm_arbiter_if.slave        bus
);

  localparam logic [EXEC_ID_W-1:0] LAST_ID = EXEC_ID_W'(NumberOfExecutors - 1);

  arb_state_e                   r_state, w_state_nxt;
  logic [NumberOfExecutors-1:0] r_grant, w_grant_nxt;
  logic [EXEC_ID_W-1:0]         r_ptr, w_ptr_nxt;
  logic [NumberOfExecutors-1:0] w_pick;
  logic [NumberOfExecutors-1:0] w_grant;
  logic [EXEC_ID_W-1:0]         w_owner_id;
  logic                         w_owner_last;
  logic                         w_owner_req;

  npcg_rr_picker #(
    .NumberOfExecutors (NumberOfExecutors)
  ) u_picker (
    .i_req    (bus.iExecReq),
    .i_ptr    (r_ptr),
    .o_winner (w_pick)
  );

  assign w_owner_id   = onehot_to_bin(MAX_EXECUTORS'(r_grant));
  assign w_owner_last = |(r_grant & bus.iExecLastStep);
  assign w_owner_req  = |(r_grant & bus.iExecReq);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (|bus.iExecReq) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ARB_OWN;
        end
      end
      ARB_OWN: begin
        // Only the owner's last step or dropped request ends ownership.
        if (w_owner_last || !w_owner_req) begin
          w_grant_nxt = '0;
          w_ptr_nxt   = (w_owner_id == LAST_ID) ? '0 : w_owner_id + 1'b1;
          w_state_nxt = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        w_grant_nxt = '0;
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Reset blanks every output immediately, not just from the next edge.
  assign w_grant        = iReset ? '0 : r_grant;
  assign bus.oExecGrant = w_grant;
  assign bus.oBusy      = !iReset && (r_state == ARB_OWN);
  assign bus.oOwnerID   = onehot_to_bin(MAX_EXECUTORS'(w_grant));

  always_comb begin
    bus.oPM_PCommand       = '0;
    bus.oPM_PCommandOption = '0;
    bus.oPM_TargetWay      = '0;
    bus.oPM_NumOfData      = '0;
    bus.oPM_CASelect       = 1'b0;
    bus.oPM_CAData         = '0;
    bus.oExecPM_Ready      = '0;
    bus.oExecPM_LastStep   = '0;
    for (int k = 0; k < NumberOfExecutors; k++) begin
      if (w_grant[k]) begin
        bus.oPM_PCommand       = bus.iExecPCommand[PCMD_W*k +: PCMD_W];
        bus.oPM_PCommandOption = bus.iExecPCommandOption[PCMD_OPT_W*k +: PCMD_OPT_W];
        bus.oPM_TargetWay      = bus.iExecTargetWay[NumberOfWays*k +: NumberOfWays];
        bus.oPM_NumOfData      = bus.iExecNumOfData[NUM_DATA_W*k +: NUM_DATA_W];
        bus.oPM_CASelect       = bus.iExecCASelect[k];
        bus.oPM_CAData         = bus.iExecCAData[CA_DATA_W*k +: CA_DATA_W];
        bus.oExecPM_Ready[PM_STATUS_W*k +: PM_STATUS_W]    = bus.iPM_Ready;
        bus.oExecPM_LastStep[PM_STATUS_W*k +: PM_STATUS_W] = bus.iPM_LastStep;
      end
    end
  end

endmodule

// File: tb/tb_npcg_toggle_pm_arbiter.sv
// Self-checking bench for npcg_toggle_pm_arbiter: per-cycle vectors push the
// expected grant onto a scoreboard that a negedge monitor pops and compares.
module tb_npcg_toggle_pm_arbiter;
  import npcg_toggle_pm_arbiter_pkg::*;

  localparam int NW = 4;
  localparam int NE = 4;

  typedef struct {
    string      nm;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [7:0] pmr;
    logic [7:0] pml;
    logic [3:0] grant;
  } vec_t;

  typedef struct {
    string      nm;
    logic [3:0] grant;
    logic [7:0] pmr;
    logic [7:0] pml;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  vec_t vecs[$];

  // Per-executor command fields driven onto the bus and expected back.
  logic [7:0]  pcmd_tab [NE] = '{8'h02, 8'h04, 8'h08, 8'h10};
  logic [2:0]  opt_tab  [NE] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [3:0]  way_tab  [NE] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [15:0] nd_tab   [NE] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
  logic        cas_tab  [NE] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0]  cad_tab  [NE] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};

  npcg_toggle_pm_arbiter_if #(.NumberOfWays(NW), .NumberOfExecutors(NE)) bus ();

  npcg_toggle_pm_arbiter #(.NumberOfWays(NW), .NumberOfExecutors(NE)) dut (
    .iSystemClock (clk),
    .iReset       (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare_cycle(input exp_t e);
    int         k;
    logic       busy;
    logic [31:0] rdy;
    logic [31:0] lst;
    k    = 0;
    busy = |e.grant;
    for (int i = 0; i < NE; i++) if (e.grant[i]) k = i;
    rdy = '0;
    lst = '0;
    if (busy) begin
      rdy[8*k +: 8] = e.pmr;
      lst[8*k +: 8] = e.pml;
    end
    check({e.nm, ".grant"}, 64'(bus.oExecGrant), 64'(e.grant));
    check({e.nm, ".busy"},  64'(bus.oBusy),      64'(busy));
    check({e.nm, ".owner"}, 64'(bus.oOwnerID),   64'(busy ? k : 0));
    check({e.nm, ".pcmd"},  64'(bus.oPM_PCommand),       64'(busy ? pcmd_tab[k] : 8'h00));
    check({e.nm, ".opt"},   64'(bus.oPM_PCommandOption), 64'(busy ? opt_tab[k]  : 3'd0));
    check({e.nm, ".way"},   64'(bus.oPM_TargetWay),      64'(busy ? way_tab[k]  : 4'd0));
    check({e.nm, ".ndata"}, 64'(bus.oPM_NumOfData),      64'(busy ? nd_tab[k]   : 16'h0));
    check({e.nm, ".casel"}, 64'(bus.oPM_CASelect),       64'(busy ? cas_tab[k]  : 1'b0));
    check({e.nm, ".cadata"},64'(bus.oPM_CAData),         64'(busy ? cad_tab[k]  : 8'h00));
    check({e.nm, ".xrdy"},  64'(bus.oExecPM_Ready),      64'(rdy));
    check({e.nm, ".xlast"}, 64'(bus.oExecPM_LastStep),   64'(lst));
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) compare_cycle(sb.pop_front());
  end

  task automatic cycle(input string nm, input logic rst_v, input logic [3:0] req,
                       input logic [3:0] last, input logic [7:0] pmr,
                       input logic [7:0] pml, input logic [3:0] grant);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = rst_v;
    bus.iExecReq      = req;
    bus.iExecLastStep = last;
    bus.iPM_Ready     = pmr;
    bus.iPM_LastStep  = pml;
    e.nm    = nm;
    e.grant = grant;
    e.pmr   = pmr;
    e.pml   = pml;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iExecReq      = '0;
    bus.iExecLastStep = '0;
    bus.iPM_Ready     = '0;
    bus.iPM_LastStep  = '0;
    for (int k = 0; k < NE; k++) begin
      bus.iExecPCommand[8*k +: 8]       = pcmd_tab[k];
      bus.iExecPCommandOption[3*k +: 3] = opt_tab[k];
      bus.iExecTargetWay[NW*k +: NW]    = way_tab[k];
      bus.iExecNumOfData[16*k +: 16]    = nd_tab[k];
      bus.iExecCASelect[k]              = cas_tab[k];
      bus.iExecCAData[8*k +: 8]         = cad_tab[k];
    end

    // Row grant = outputs seen in that cycle, from state registered at its start.
    vecs.push_back('{"rst0",            1'b1, 4'b0000, 4'b0000, 8'hC3, 8'h00, 4'b0000});
    vecs.push_back('{"rst1",            1'b1, 4'b0000, 4'b0000, 8'hC3, 8'h00, 4'b0000});
    vecs.push_back('{"rr_req",          1'b0, 4'b1011, 4'b0000, 8'hC3, 8'h00, 4'b0000});
    vecs.push_back('{"rr_g0",           1'b0, 4'b1011, 4'b0000, 8'hC3, 8'h00, 4'b0001});
    vecs.push_back('{"rr_g0_other_last",1'b0, 4'b1011, 4'b1000, 8'hC3, 8'h00, 4'b0001});
    vecs.push_back('{"rr_g0_last",      1'b0, 4'b1011, 4'b0001, 8'hC3, 8'h00, 4'b0001});
    vecs.push_back('{"rr_rel0",         1'b0, 4'b1011, 4'b0000, 8'hC3, 8'h00, 4'b0000});
    vecs.push_back('{"rr_idle0",        1'b0, 4'b1011, 4'b0000, 8'hC3, 8'h00, 4'b0000});
    vecs.push_back('{"rr_g1",           1'b0, 4'b1011, 4'b0000, 8'hC3, 8'h00, 4'b0010});
    vecs.push_back('{"iso_g1_last",     1'b0, 4'b1011, 4'b0010, 8'hC3, 8'h01, 4'b0010});
    vecs.push_back('{"rr_rel1",         1'b0, 4'b1011, 4'b0000, 8'hC3, 8'h00, 4'b0000});
    vecs.push_back('{"rr_idle1",        1'b0, 4'b1011, 4'b0000, 8'hC3, 8'h00, 4'b0000});
    vecs.push_back('{"rr_g3",           1'b0, 4'b1011, 4'b0000, 8'hC3, 8'h00, 4'b1000});
    vecs.push_back('{"rr_g3_last",      1'b0, 4'b1011, 4'b1000, 8'hC3, 8'h00, 4'b1000});
    vecs.push_back('{"rel3_wrap",       1'b0, 4'b0000, 4'b0000, 8'hC3, 8'h00, 4'b0000});
    vecs.push_back('{"single_req",      1'b0, 4'b0100, 4'b0000, 8'hC3, 8'h00, 4'b0000});
    vecs.push_back('{"single_g2",       1'b0, 4'b0100, 4'b0000, 8'h5A, 8'h00, 4'b0100});
    vecs.push_back('{"single_g2_last",  1'b0, 4'b0100, 4'b0100, 8'hC3, 8'h80, 4'b0100});
    vecs.push_back('{"single_rel2",     1'b0, 4'b0000, 4'b0000, 8'hC3, 8'h00, 4'b0000});

    foreach (vecs[i]) begin
      cycle(vecs[i].nm, vecs[i].rst, vecs[i].req, vecs[i].last,
            vecs[i].pmr, vecs[i].pml, vecs[i].grant);
    end

    // Abort: owner 1 (pointer at 3) drops its request without a last step.
    cycle("ab_idle",    1'b0, 4'b0000, 4'b0000, 8'hC3, 8'h00, 4'b0000);
    cycle("ab_req",     1'b0, 4'b0010, 4'b0000, 8'hC3, 8'h00, 4'b0000);
    cycle("ab_g1",      1'b0, 4'b0010, 4'b0000, 8'hC3, 8'h00, 4'b0010);
    cycle("ab_drop",    1'b0, 4'b0000, 4'b0000, 8'hC3, 8'h00, 4'b0010);
    cycle("ab_release", 1'b0, 4'b0000, 4'b0000, 8'hC3, 8'h00, 4'b0000);
    cycle("ab_idle2",   1'b0, 4'b0000, 4'b0000, 8'hC3, 8'h00, 4'b0000);

    // Reset while executor 3 owns (pointer at 2); pointer must return to 0.
    cycle("mr_req",     1'b0, 4'b1010, 4'b0000, 8'hC3, 8'h00, 4'b0000);
    cycle("mr_g3",      1'b0, 4'b1010, 4'b0000, 8'hC3, 8'h00, 4'b1000);
    cycle("mr_rst",     1'b1, 4'b1010, 4'b0000, 8'hC3, 8'h00, 4'b0000);
    cycle("mr_after",   1'b0, 4'b1010, 4'b0000, 8'hC3, 8'h00, 4'b0000);
    cycle("mr_g1",      1'b0, 4'b1010, 4'b0000, 8'hC3, 8'h00, 4'b0010);

    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
